// File: rtl/id_serial_tx.sv
// Framed serial transmitter for the 20-bit ID word.
// Sends start bit, data LSB first, optional even parity, then stop bit.
module id_serial_tx #(
    parameter int DATA_W       = 20,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] id_num,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_n;
    logic [TW-1:0]     tick_q, tick_n;
    logic [BW-1:0]     bit_q, bit_n;
    logic [DATA_W-1:0] shreg_q, shreg_n;
    logic [DATA_W-1:0] shifted;
    logic              par_q, par_n;
    logic              tx_q, tx_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              tick_end;
    logic              bit_end;

    assign tick_end = (tick_q == TW'(CLKS_PER_BIT - 1));
    assign bit_end  = (bit_q == BW'(DATA_W - 1));
    assign shifted  = shreg_q >> 1;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            tick_q  <= tick_n;
            bit_q   <= bit_n;
            shreg_q <= shreg_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // tx_n is the level the line takes after the coming edge
    always_comb begin
        state_n = state_q;
        tick_n  = tick_q;
        bit_n   = bit_q;
        shreg_n = shreg_q;
        par_n   = par_q;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    state_n = S_START;
                    shreg_n = id_num;
                    par_n   = ^id_num;
                    tick_n  = '0;
                    bit_n   = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (tick_end) begin
                    tick_n  = '0;
                    state_n = S_DATA;
                    tx_n    = shreg_q[0];
                end else begin
                    tick_n = tick_q + TW'(1);
                end
            end
            S_DATA: begin
                if (tick_end) begin
                    tick_n  = '0;
                    shreg_n = shifted;
                    if (bit_end) begin
                        bit_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_q + BW'(1);
                        tx_n  = shifted[0];
                    end
                end else begin
                    tick_n = tick_q + TW'(1);
                end
            end
            S_PARITY: begin
                if (tick_end) begin
                    tick_n  = '0;
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end else begin
                    tick_n = tick_q + TW'(1);
                end
            end
            S_STOP: begin
                if (tick_end) begin
                    tick_n  = '0;
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    tick_n = tick_q + TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
